// File: rtl/miriscv_alu_pkg.sv
// miriscv_alu_pkg: ALU opcode encodings and ALU arbiter port typedefs.
package miriscv_alu_pkg;
  localparam int ALU_OPW = 4;
  localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_SLL  = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_SLTU = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OPW-1:0] ALU_SRL  = 4'd5;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 4'd6;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 4'd7;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'd8;
  localparam logic [ALU_OPW-1:0] ALU_SRA  = 4'd13;
  localparam int ALU_ARB_PORTS = 2;
  typedef logic [$clog2(ALU_ARB_PORTS)-1:0] alu_arb_port_t;
endpackage

// File: rtl/miriscv_pkg.sv
// miriscv_pkg: core-wide parameters shared by the miriscv blocks.
package miriscv_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/miriscv_alu_arb_rsp_buf.sv
// miriscv_alu_arb_rsp_buf: one-entry response buffer; a load in the same cycle as a drain refills without a bubble.
module miriscv_alu_arb_rsp_buf #(
  parameter int XLEN = miriscv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic [XLEN-1:0] data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);
  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  always_comb begin
    valid_d = load_i | (valid_q & ~drain_i);
    data_d  = load_i ? data_i : data_q;
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/miriscv_alu_arb.sv
// miriscv_alu_arb: shares one external ALU between two requesters with 1-cycle buffered responses.
// Define MIRISCV_ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module miriscv_alu_arb
  import miriscv_alu_pkg::*;
#(
  parameter int XLEN = miriscv_pkg::XLEN,
  parameter int OPW  = 4
) (
  input  logic                                   clk_i,
  input  logic                                   arst_i,
  input  logic [ALU_ARB_PORTS-1:0]               req_valid_i,
  output logic [ALU_ARB_PORTS-1:0]               req_ready_o,
  input  logic [ALU_ARB_PORTS-1:0][XLEN-1:0]     req_a_i,
  input  logic [ALU_ARB_PORTS-1:0][XLEN-1:0]     req_b_i,
  input  logic [ALU_ARB_PORTS-1:0][OPW-1:0]      req_op_i,
  output logic [ALU_ARB_PORTS-1:0]               rsp_valid_o,
  input  logic [ALU_ARB_PORTS-1:0]               rsp_ready_i,
  output logic [ALU_ARB_PORTS-1:0][XLEN-1:0]     rsp_result_o,
  output logic [XLEN-1:0]                        alu_port_a_o,
  output logic [XLEN-1:0]                        alu_port_b_o,
  output logic [OPW-1:0]                         alu_op_o,
  input  logic [XLEN-1:0]                        alu_result_i,
  output logic                                   busy_o
);
  logic [ALU_ARB_PORTS-1:0] elig, grant;
  alu_arb_port_t            sel;
  // A buffer being drained this cycle can accept its replacement immediately.
  assign elig = req_valid_i & (~rsp_valid_o | rsp_ready_i);
`ifdef MIRISCV_ALU_ARB_RR_EN
  alu_arb_port_t last_q, last_d;
  always_comb begin
    grant  = (&elig) ? {~last_q, last_q} : elig;
    last_d = (|grant) ? alu_arb_port_t'(grant[1]) : last_q;
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  always_comb grant = elig[0] ? 2'b01 : elig;
`endif
  always_comb begin
    sel          = alu_arb_port_t'(grant[1]);
    alu_port_a_o = (|grant) ? req_a_i[sel]  : '0;
    alu_port_b_o = (|grant) ? req_b_i[sel]  : '0;
    alu_op_o     = (|grant) ? req_op_i[sel] : '0;
  end
  assign req_ready_o = grant;
  assign busy_o      = |rsp_valid_o;
  for (genvar p = 0; p < ALU_ARB_PORTS; p++) begin : g_buf
    miriscv_alu_arb_rsp_buf #(.XLEN(XLEN)) u_buf (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .load_i  (grant[p]),
      .drain_i (rsp_ready_i[p]),
      .data_i  (alu_result_i),
      .valid_o (rsp_valid_o[p]),
      .data_o  (rsp_result_o[p])
    );
  end
endmodule

// File: tb/tb_miriscv_alu_arb.sv
// tb_miriscv_alu_arb: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_miriscv_alu_arb;
  import miriscv_alu_pkg::*;
  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a = '0;
  logic [1:0][31:0] req_b = '0;
  logic [1:0][3:0]  req_op = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [1:0][31:0] rsp_result;
  logic [31:0]      alu_a, alu_b, alu_res;
  logic [3:0]       alu_op;
  logic             busy;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_op, alu_a, alu_b);

  miriscv_alu_arb #(.XLEN(32), .OPW(4)) dut (
    .clk_i(clk), .arst_i(arst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .alu_port_a_o(alu_a), .alu_port_b_o(alu_b), .alu_op_o(alu_op),
    .alu_result_i(alu_res), .busy_o(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    arst = 1'b1;
    #2;
    arst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 4;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", rsp_valid); end
    if (rsp_result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", rsp_result); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    arst = 1'b0;
    req_valid = 2'b01; req_a[0] = 32'd5; req_b[0] = 32'd3; req_op[0] = ALU_ADD;
    tick();
    req_valid = 2'b00;
    #2 arst = 1'b1;
    #1;
    checks += 2;
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL async_reset_valid: got %b want 00", rsp_valid); end
    if (rsp_result !== 64'd0) begin errors++; $display("FAIL async_reset_result: got %h want 0", rsp_result); end
    @(negedge clk);
    arst = 1'b0;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks += 2;
    if (rsp_valid !== 2'b01) begin errors++; $display("FAIL post_reset_rsp_valid: got %b want 01", rsp_valid); end
    if (rsp_result[0] !== 32'd8) begin errors++; $display("FAIL post_reset_result: got %h want 8", rsp_result[0]); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3] = '{ALU_ADD, ALU_SUB, ALU_XOR};
    logic [31:0] as  [3] = '{32'd1, 32'd10, 32'hF0};
    logic [31:0] bs  [3] = '{32'd2, 32'd4, 32'h0F};
    logic [31:0] ex  [3] = '{32'd3, 32'd6, 32'hFF};
    do_reset();
    rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b01; req_a[0] = as[i]; req_b[0] = bs[i]; req_op[0] = ops[i];
      @(negedge clk);
      checks++;
      if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready[0]); end
      tick();
      checks += 2;
      if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, rsp_valid[0]); end
      if (rsp_result[0] !== ex[i]) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, rsp_result[0], ex[i]); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_conflict();
    logic [1:0] want;
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    req_a = {32'd7, 32'd9}; req_b = {32'd1, 32'd2}; req_op = {ALU_ADD, ALU_ADD};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef MIRISCV_ALU_ARB_RR_EN
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      want = 2'b01;
`endif
      checks++;
      if (req_ready !== want) begin errors++; $display("FAIL conflict_grant[%0d]: got %b want %b", i, req_ready, want); end
      tick();
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 2'b10; req_a[1] = 32'h10; req_b[1] = 32'h01; req_op[1] = ALU_OR;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_first_ready: got %b want 10", req_ready); end
    tick();
    req_a[1] = 32'h20; req_b[1] = 32'h02;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks += 3;
      if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, rsp_valid[1]); end
      if (rsp_result[1] !== 32'h11) begin errors++; $display("FAIL bp_hold_result[%0d]: got %h want 11", i, rsp_result[1]); end
      if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_blocked[%0d]: got %b want 0", i, req_ready[1]); end
      tick();
    end
    #2 rsp_ready = 2'b10;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", req_ready[1]); end
    tick();
    req_valid = 2'b00;
    checks += 2;
    if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_refill_valid: got %b want 1", rsp_valid[1]); end
    if (rsp_result[1] !== 32'h22) begin errors++; $display("FAIL bp_refill_result: got %h want 22", rsp_result[1]); end
    tick();
    checks += 2;
    if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_drained_valid: got %b want 0", rsp_valid[1]); end
    if (rsp_result[1] !== 32'h22) begin errors++; $display("FAIL bp_drained_hold: got %h want 22", rsp_result[1]); end
  endtask

  task automatic test_isolation();
    do_reset();
    req_valid = 2'b01; req_a[0] = 32'd1; req_b[0] = 32'd4; req_op[0] = ALU_SLL;
    tick();
    req_valid = 2'b10; req_a[1] = 32'h8000_0000; req_b[1] = 32'd4; req_op[1] = ALU_SRA;
    tick();
    req_valid = 2'b00;
    checks += 3;
    if (rsp_valid !== 2'b11) begin errors++; $display("FAIL iso_valid: got %b want 11", rsp_valid); end
    if (rsp_result[0] !== 32'h10) begin errors++; $display("FAIL iso_port0: got %h want 00000010", rsp_result[0]); end
    if (rsp_result[1] !== 32'hF800_0000) begin errors++; $display("FAIL iso_port1: got %h want f8000000", rsp_result[1]); end
  endtask

  task automatic test_idle();
    do_reset();
    req_a = {32'hDEAD_BEEF, 32'h1234_5678}; req_b = {32'hCAFE_F00D, 32'h0BAD_F00D}; req_op = {ALU_SUB, ALU_XOR};
    @(negedge clk);
    checks += 4;
    if (alu_op !== 4'd0) begin errors++; $display("FAIL idle_op: got %h want 0", alu_op); end
    if (alu_a !== 32'd0) begin errors++; $display("FAIL idle_a: got %h want 0", alu_a); end
    if (alu_b !== 32'd0) begin errors++; $display("FAIL idle_b: got %h want 0", alu_b); end
    if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b want 00", req_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  op_list [10] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};
    bit          m_val [2];
    logic [31:0] m_dat [2];
    int          m_last, g;
    bit          el [2];
    logic [1:0]  want_ready;
    do_reset();
    m_val = '{0, 0}; m_dat = '{32'd0, 32'd0}; m_last = 1;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[p] && $urandom_range(0, 2) != 0) begin
          req_valid[p] = 1'b1;
          req_a[p] = $urandom; req_b[p] = $urandom;
          req_op[p] = op_list[$urandom_range(0, 9)];
        end
        rsp_ready[p] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int p = 0; p < 2; p++) el[p] = req_valid[p] && (!m_val[p] || rsp_ready[p]);
      if (el[0] && el[1]) begin
`ifdef MIRISCV_ALU_ARB_RR_EN
        g = (m_last == 0) ? 1 : 0;
`else
        g = 0;
`endif
      end else g = el[0] ? 0 : (el[1] ? 1 : -1);
      want_ready = (g < 0) ? 2'b00 : 2'(1 << g);
      checks += 5;
      if (req_ready !== want_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, want_ready); end
      if (rsp_valid !== {m_val[1], m_val[0]}) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, rsp_valid, {m_val[1], m_val[0]}); end
      if (rsp_result[0] !== m_dat[0]) begin errors++; $display("FAIL rnd_result0[%0d]: got %h want %h", c, rsp_result[0], m_dat[0]); end
      if (rsp_result[1] !== m_dat[1]) begin errors++; $display("FAIL rnd_result1[%0d]: got %h want %h", c, rsp_result[1], m_dat[1]); end
      if (busy !== (m_val[0] | m_val[1])) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy, m_val[0] | m_val[1]); end
      if (g >= 0) begin
        checks += 2;
        if (alu_op !== req_op[g]) begin errors++; $display("FAIL rnd_alu_op[%0d]: got %h want %h", c, alu_op, req_op[g]); end
        if (alu_a !== req_a[g] || alu_b !== req_b[g]) begin errors++; $display("FAIL rnd_alu_ab[%0d]: got %h/%h want %h/%h", c, alu_a, alu_b, req_a[g], req_b[g]); end
      end
      for (int p = 0; p < 2; p++) begin
        if (g == p) begin
          m_val[p] = 1;
          m_dat[p] = alu_f(req_op[p], req_a[p], req_b[p]);
        end else if (rsp_ready[p]) m_val[p] = 0;
      end
      if (g >= 0) m_last = g;
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_conflict();
    test_backpressure();
    test_isolation();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/miriscv_alu_arb.md
# miriscv_alu_arb

Two-port arbiter that shares a single `miriscv_alu` instance between the integer pipeline (port 0) and a secondary requester such as the CSR/address-generation unit (port 1). It accepts operand/opcode requests on valid/ready handshakes and drives the winning request onto the ALU ports. It captures the ALU result into a per-port one-entry response buffer and returns it on a valid/ready response channel. The ALU itself stays outside this block; only its `alu_port_a/b`, `alu_op` and `alu_result` paths pass through here.

## Interface
- `XLEN`, default `miriscv_pkg::XLEN` (32): operand/result width.
- `OPW`, default 4: ALU opcode width; encoding per `miriscv_alu_pkg`.
- `clk_i` in 1: clock, rising edge.
- `arst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 2: per-port request valid; bit p belongs to port p.
- `req_ready_o` out 2: per-port request accepted this cycle.
- `req_a_i` in 2×XLEN: per-port operand A.
- `req_b_i` in 2×XLEN: per-port operand B.
- `req_op_i` in 2×OPW: per-port ALU opcode.
- `rsp_valid_o` out 2: per-port response buffer full.
- `rsp_ready_i` in 2: per-port response consumed.
- `rsp_result_o` out 2×XLEN: per-port buffered result.
- `alu_port_a_o`, `alu_port_b_o` out XLEN: operands to the ALU. Both are 0 when there is no grant.
- `alu_op_o` out OPW: opcode to the ALU. It is 0 (ADD) when there is no grant.
- `alu_result_i` in XLEN: combinational result from the ALU.
- `busy_o` out 1: high when any `rsp_valid_o` bit is set.

## Operation
- Eligibility: port p is eligible when `req_valid_i[p]` is high and its response buffer is empty, or is being drained this cycle (`rsp_valid_o[p] & rsp_ready_i[p]`).
- Grant: at most one port per cycle. `req_ready_o[p]` equals `grant[p]`.
- Grant policy:
  - Only one port eligible: that port wins.
  - Both eligible: policy per Configuration.
- Grant muxing: the granted port's A, B and op drive the ALU combinationally, in the same cycle.
- Capture: on acceptance, `alu_result_i` is written into that port's buffer and `rsp_valid_o[p]` is set at the next edge.
- Simultaneous drain and accept on the same port: the new result overwrites the buffer and `rsp_valid_o[p]` stays 1. No bubble.
- Drain with no accept: `rsp_valid_o[p]` clears at the next edge, and the buffer data holds its last value.
- Requester rules:
  - Once asserted, `req_valid_i[p]` and its payload stay stable until `req_ready_o[p]`. A bench checks this.
  - The arbiter's own behaviour never depends on the requester dropping valid.
- Responses are in order per port, with exactly one response per accepted request. Nothing crosses between ports.
- No combinational path from `rsp_ready_i` to `rsp_valid_o`. The path from `rsp_ready_i` to `req_ready_o` is allowed, because it enables back-to-back throughput.

## Timing
- Request-to-response latency: 1 cycle (accept at edge N, `rsp_valid_o` high after edge N).
- Throughput: one accept per cycle in total across both ports. A single port sustains 1/cycle if its `rsp_ready_i` is held high.
- Reset values:
  - `req_ready_o` = 0 while no request is valid.
  - `rsp_valid_o` = 0, `rsp_result_o` = 0, `busy_o` = 0.
  - Round-robin pointer = 1, so port 0 wins the first conflict.
- Reset mid-operation: buffered results are discarded and responses are not replayed. Requesters must also be reset.
- Arithmetic: no width change; `alu_result_i` is stored verbatim at XLEN bits.

## Configuration
- `MIRISCV_ALU_ARB_RR_EN` defined: round-robin arbitration.
  - One-bit pointer `last_q` records the last granted port and is updated only on an actual accept.
  - On conflict, the port not equal to `last_q` wins.
- `MIRISCV_ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins a conflict.
  - No pointer register; port 1 can starve.

## Structure
- In `miriscv_alu_pkg`: the port-count localparam `ALU_ARB_PORTS = 2` and the port-index typedef `alu_arb_port_t`.
- Opcode encodings are reused from `miriscv_alu_pkg`; no new opcodes.
- One sub-module, `miriscv_alu_arb_rsp_buf`, is instantiated per port. It holds the one-entry response buffer: valid flag, XLEN data, and load/drain logic.
- Arbitration and operand muxing sit in the top level.

## Test plan
- **Reset:** assert `arst_i` asynchronously mid-cycle, with port 0 holding A=5 and B=3 → `rsp_valid_o`=00 and results 0 immediately. After release, the first accept on port 0 returns 8 one cycle later.
- **Single port, back-to-back:** port 0 issues ADD 1+2, SUB 10−4, XOR F0^0F with `rsp_ready_i`=1 → `req_ready_o[0]`=1 for 3 cycles and responses 3, 6, FF on consecutive cycles.
- **Conflict:** both ports valid every cycle with `rsp_ready_i`=11 → with RR enabled, grants alternate 0,1,0,1; with RR disabled, port 0 gets every grant and port 1 none.
- **Backpressure:**
  - Port 1 completes OR 0x10|0x01 while `rsp_ready_i[1]`=0 → `rsp_valid_o[1]` holds 0x11 and the next port-1 request sees `req_ready_o[1]`=0.
  - Raise `rsp_ready_i[1]` → the new request is accepted in that same cycle.
- **Cross-port isolation:** port 0 SLL 1<<4 and port 1 SRA 0x80000000>>>4 accepted on consecutive cycles → port 0 gets 0x10 and port 1 gets 0xF8000000, with no cross-contamination.
- **Idle:** no requests → `alu_op_o`=0 and operands 0.
